eco32f_regfile_mp: RTL and testbench
====================================

ECO32F_REGFILE_MP -- requirements
Module: eco32f_regfile_mp

Interface
REQ-001 Parameter DATA_WIDTH, default 32, register width in bits.
REQ-002 Parameter ADDR_WIDTH, default 5, register index width; register count NREGS = 2**ADDR_WIDTH.
REQ-003 Parameter NREAD, default 2, number of read ports (1..4).
REQ-004 Parameter ZERO_REG, default 1, when 1 register 0 reads as zero regardless of writes.
REQ-005 Parameter CLEAR_ON_RESET, default 1, when 1 all registers are zeroed by a sweep after reset.
REQ-006 clk  in  1  sole clock; all state updates on rising edge.
REQ-007 rst  in  1  asynchronous, active-low reset.
REQ-008 rd_addr  in  NREAD*ADDR_WIDTH  fetch-stage read indices; port p at bits [p*ADDR_WIDTH +: ADDR_WIDTH].
REQ-009 rd_en  in  1  advance decode stage (not stalled); captures rd_addr and performs RAM read.
REQ-010 rd_used  in  NREAD  decode-stage port p actually consumes its operand (hazard qualification).
REQ-011 rd_data  out  NREAD*DATA_WIDTH  decode-stage operands, same packing as rd_addr.
REQ-012 mem_addr, mem_we, mem_load, mem_data  in  ADDR_WIDTH/1/1/DATA_WIDTH  mem-stage destination, write enable, result-is-load-pending flag, result.
REQ-013 wb_addr, wb_we, wb_data  in  ADDR_WIDTH/1/DATA_WIDTH  writeback write port.
REQ-014 load_use_stall  out  1  decode operand depends on a mem-stage load whose data is not yet available.
REQ-015 ready  out  1  register file usable; low during clear sweep.

Function
REQ-016 On rd_en=1 at a rising edge, id_addr[p] <= rd_addr[p] and RAM port p reads rd_addr[p]; on rd_en=0 id_addr and RAM output hold.
REQ-017 RAM read SHALL be write-first: same-edge wb write to the read index returns wb_data.
REQ-018 rd_data[p] priority per cycle: (ZERO_REG and id_addr[p]==0) -> 0; mem_we and mem_addr==id_addr[p] -> mem_data; wb_we and wb_addr==id_addr[p] -> wb_data; fresh -> RAM output; else held[p].
REQ-019 fresh = rd_en registered one cycle; held[p] <= rd_data[p] every cycle fresh or bypass selected, so writes during a stall are retained.
REQ-020 load_use_stall = OR over p of rd_used[p] & mem_we & mem_load & (mem_addr==id_addr[p]) & !(ZERO_REG & id_addr[p]==0); combinational, zero latency.
REQ-021 wb_we with ZERO_REG=1 and wb_addr==0 SHALL not alter observable register 0.
REQ-022 Simultaneous mem and wb match on same index: mem_data wins (younger).
REQ-023 Multiple read ports on same index SHALL return identical data the same cycle.
REQ-024 FSM states CLEAR, RUN; CLEAR writes 0 to index cnt each cycle, cnt increments 0..NREGS-1, enters RUN after writing NREGS-1; CLEAR lasts exactly NREGS cycles.
REQ-025 In CLEAR: wb_we ignored, rd_data all zero, load_use_stall=0, ready=0; in RUN ready=1.
REQ-026 CLEAR_ON_RESET=0: FSM enters RUN directly after reset, ready=1 first cycle; RAM contents undefined until written.

Reset
REQ-027 rst low (any time, incl. mid-sweep or mid-stall) asynchronously sets state=CLEAR (or RUN if CLEAR_ON_RESET=0), cnt=0, ready=0 (1 if no clear), fresh=0, id_addr=0, held=0.
REQ-028 After rst deasserts, first rising edge begins sweep at index 0; rd_data=0 and load_use_stall=0 throughout reset.

Verification
REQ-029 Reset release, defaults -> ready low exactly 32 cycles then high; read all 32 indices -> 0.
REQ-030 wb write r5=0xDEADBEEF same edge as rd_en read of r5 -> rd_data port0 = 0xDEADBEEF next cycle.
REQ-031 Decode r7 with mem_we r7=0x11111111 and wb_we r7=0x22222222 same cycle -> 0x11111111; mem drop -> 0x22222222.
REQ-032 rd_en=0 for 3 cycles on r9, wb writes r9=0xA5A5A5A5 in cycle 2 -> rd_data stays 0xA5A5A5A5 through stall and after rd_en=1 re-read.
REQ-033 mem_load=1 mem_addr=3, decode port1 r3 rd_used=10 -> load_use_stall=1; rd_used=00 or index 0 -> 0.
REQ-034 wb write r0=0xFFFFFFFF then read r0 on all ports -> 0; rst pulsed mid-sweep at cnt=10 -> sweep restarts, ready after 32 cycles.

Source files
------------

// File: rtl/eco32f_regfile_mp.sv
// Multi-read-port register file: registered reads with decode-stage mem/wb bypass,
// load-use hazard detection and an optional zeroing sweep after reset.
module eco32f_regfile_mp #(
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned ADDR_WIDTH     = 5,
  parameter int unsigned NREAD          = 2,
  parameter int unsigned ZERO_REG       = 1,
  parameter int unsigned CLEAR_ON_RESET = 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NREAD*ADDR_WIDTH-1:0] rd_addr,
  input  logic                        rd_en,
  input  logic [NREAD-1:0]            rd_used,
  output logic [NREAD*DATA_WIDTH-1:0] rd_data,
  input  logic [ADDR_WIDTH-1:0]       mem_addr,
  input  logic                        mem_we,
  input  logic                        mem_load,
  input  logic [DATA_WIDTH-1:0]       mem_data,
  input  logic [ADDR_WIDTH-1:0]       wb_addr,
  input  logic                        wb_we,
  input  logic [DATA_WIDTH-1:0]       wb_data,
  output logic                        load_use_stall,
  output logic                        ready
);

  localparam int unsigned NREGS = 1 << ADDR_WIDTH;

  typedef enum logic {StClear, StRun} state_e;

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   cnt_q, cnt_d;
  logic                    clearing;
  logic                    active;
  logic                    fresh_q;
  logic                    we_eff;
  logic [ADDR_WIDTH-1:0]   waddr_eff;
  logic [DATA_WIDTH-1:0]   wdata_eff;
  logic [DATA_WIDTH-1:0]   regs_q [NREGS];
  logic [NREAD-1:0]        stall_vec;

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= (CLEAR_ON_RESET != 0) ? StClear : StRun;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (state_q == StClear) begin
      cnt_d = cnt_q + 1'b1;
      if (cnt_q == ADDR_WIDTH'(NREGS - 1)) begin
        state_d = StRun;
      end
    end
  end

  // FSM outputs
  always_comb begin
    clearing = (state_q == StClear);
    ready    = (state_q == StRun);
  end

  // Operands are forced to zero while reset is held, not just once it is sampled.
  assign active = rst && ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) fresh_q <= 1'b0;
    else      fresh_q <= rd_en;
  end

  // Single write port shared by the clear sweep and writeback.
  always_comb begin
    we_eff    = clearing || (ready && wb_we);
    waddr_eff = clearing ? cnt_q : wb_addr;
    wdata_eff = clearing ? '0 : wb_data;
  end

  always_ff @(posedge clk) begin
    if (we_eff) regs_q[waddr_eff] <= wdata_eff;
  end

  for (genvar gp = 0; gp < int'(NREAD); gp++) begin : g_port
    logic [ADDR_WIDTH-1:0] ra;
    logic [ADDR_WIDTH-1:0] id_addr_q;
    logic [DATA_WIDTH-1:0] ram_out_q;
    logic [DATA_WIDTH-1:0] held_q;
    logic [DATA_WIDTH-1:0] data;
    logic                  zero_hit, mem_hit, wb_hit;

    assign ra = rd_addr[gp*ADDR_WIDTH +: ADDR_WIDTH];

    // Write-first read: a same-edge write to the read index is returned directly.
    always_ff @(posedge clk) begin
      if (rd_en) begin
        ram_out_q <= (we_eff && (waddr_eff == ra)) ? wdata_eff : regs_q[ra];
      end
    end

    always_comb begin
      zero_hit = (ZERO_REG != 0) && (id_addr_q == '0);
      mem_hit  = mem_we && (mem_addr == id_addr_q);
      wb_hit   = wb_we && (wb_addr == id_addr_q);
      data     = held_q;
      if (!active || zero_hit) data = '0;
      else if (mem_hit)        data = mem_data;
      else if (wb_hit)         data = wb_data;
      else if (fresh_q)        data = ram_out_q;
    end

    // Held copy tracks whatever was shown, so bypassed writes survive a stall.
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        id_addr_q <= '0;
        held_q    <= '0;
      end else begin
        if (rd_en) id_addr_q <= ra;
        if (fresh_q || mem_hit || wb_hit) held_q <= data;
      end
    end

    assign rd_data[gp*DATA_WIDTH +: DATA_WIDTH] = data;
    assign stall_vec[gp] = active && rd_used[gp] && mem_we && mem_load &&
                           (mem_addr == id_addr_q) && !zero_hit;
  end

  assign load_use_stall = |stall_vec;

endmodule

// File: tb/tb_eco32f_regfile_mp.sv
// Randomized bench for eco32f_regfile_mp against an architectural register/operand model,
// plus directed bypass, stall, zero-register and reset-sweep scenarios.
module tb_eco32f_regfile_mp;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int NR = 2;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic [NR*AW-1:0] rd_addr;
  logic            rd_en;
  logic [NR-1:0]   rd_used;
  logic [NR*DW-1:0] rd_data;
  logic [AW-1:0]   mem_addr;
  logic            mem_we;
  logic            mem_load;
  logic [DW-1:0]   mem_data;
  logic [AW-1:0]   wb_addr;
  logic            wb_we;
  logic [DW-1:0]   wb_data;
  logic            load_use_stall;
  logic            ready;

  int checks   = 0;
  int failures = 0;

  // Reference model: architectural registers and the operand each decode port holds.
  logic [31:0] arch [32];
  logic [4:0]  id_m [NR];
  logic [31:0] op_m [NR];

  eco32f_regfile_mp dut (
    .clk            (clk),
    .rst            (rst),
    .rd_addr        (rd_addr),
    .rd_en          (rd_en),
    .rd_used        (rd_used),
    .rd_data        (rd_data),
    .mem_addr       (mem_addr),
    .mem_we         (mem_we),
    .mem_load       (mem_load),
    .mem_data       (mem_data),
    .wb_addr        (wb_addr),
    .wb_we          (wb_we),
    .wb_data        (wb_data),
    .load_use_stall (load_use_stall),
    .ready          (ready)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] exp_port(input int p);
    if (id_m[p] == 5'd0) return 32'd0;
    if (mem_we && mem_addr == id_m[p]) return mem_data;
    if (wb_we && wb_addr == id_m[p]) return wb_data;
    return op_m[p];
  endfunction

  function automatic logic exp_stall();
    logic s = 1'b0;
    for (int p = 0; p < NR; p++) begin
      if (rd_used[p] && mem_we && mem_load && mem_addr == id_m[p] && id_m[p] != 5'd0) s = 1'b1;
    end
    return s;
  endfunction

  function automatic logic [31:0] port(input int p);
    return rd_data[p*DW +: DW];
  endfunction

  task automatic set_addr(input int p, input logic [AW-1:0] a);
    rd_addr[p*AW +: AW] = a;
  endtask

  task automatic idle();
    rd_en = 1'b0; rd_addr = '0; rd_used = '0;
    mem_we = 1'b0; mem_load = 1'b0; mem_addr = '0; mem_data = '0;
    wb_we = 1'b0; wb_addr = '0; wb_data = '0;
  endtask

  task automatic model_clear();
    for (int i = 0; i < 32; i++) arch[i] = 32'd0;
    for (int p = 0; p < NR; p++) begin
      id_m[p] = '0;
      op_m[p] = 32'd0;
    end
  endtask

  // Compare current outputs with the model, then clock once and advance the model.
  task automatic step();
    logic [31:0] e [NR];
    #2;
    for (int p = 0; p < NR; p++) begin
      e[p] = exp_port(p);
      check_eq($sformatf("rd_data_p%0d", p), port(p), e[p]);
    end
    check_eq("stall", {31'd0, load_use_stall}, {31'd0, exp_stall()});
    check_eq("ready_run", {31'd0, ready}, 32'd1);
    @(posedge clk);
    if (wb_we) arch[wb_addr] = wb_data;
    for (int p = 0; p < NR; p++) op_m[p] = e[p];
    if (rd_en) begin
      for (int p = 0; p < NR; p++) begin
        id_m[p] = rd_addr[p*AW +: AW];
        op_m[p] = arch[id_m[p]];
      end
    end
    #1;
  endtask

  task automatic wait_ready(input string tag);
    int n = 0;
    while (ready !== 1'b1 && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    check_eq(tag, n, 32);
  endtask

  task automatic read_all();
    for (int i = 0; i < 32; i++) begin
      idle();
      rd_en = 1'b1;
      set_addr(0, AW'(i));
      set_addr(1, AW'(31 - i));
      step();
    end
    idle();
    step();
  endtask

  initial begin
    idle();
    model_clear();
    rst = 1'b0;
    mem_we = 1'b1; mem_load = 1'b1; rd_used = '1;
    #3;
    check_eq("rst_rd_p0", port(0), 32'd0);
    check_eq("rst_rd_p1", port(1), 32'd0);
    check_eq("rst_ready", {31'd0, ready}, 32'd0);
    check_eq("rst_stall", {31'd0, load_use_stall}, 32'd0);
    idle();
    @(negedge clk);
    rst = 1'b1;
    wait_ready("ready_latency");
    read_all();

    // Write-first read of r5
    idle(); wb_we = 1'b1; wb_addr = 5'd5; wb_data = 32'hDEADBEEF;
    rd_en = 1'b1; set_addr(0, 5'd5);
    step();
    idle();
    #1 check_eq("write_first_r5", port(0), 32'hDEADBEEF);
    step();

    // mem beats wb on the same index, wb shows through when mem drops
    idle(); rd_en = 1'b1; set_addr(0, 5'd7); step();
    idle(); mem_we = 1'b1; mem_addr = 5'd7; mem_data = 32'h11111111;
    wb_we = 1'b1; wb_addr = 5'd7; wb_data = 32'h22222222;
    #1 check_eq("mem_over_wb", port(0), 32'h11111111);
    step();
    mem_we = 1'b0;
    #1 check_eq("wb_after_mem_drop", port(0), 32'h22222222);
    step();

    // Write during a stall is retained and re-read
    idle(); rd_en = 1'b1; set_addr(0, 5'd9); step();
    idle(); step();
    wb_we = 1'b1; wb_addr = 5'd9; wb_data = 32'hA5A5A5A5;
    #1 check_eq("stall_wb_bypass", port(0), 32'hA5A5A5A5);
    step();
    idle();
    #1 check_eq("stall_held", port(0), 32'hA5A5A5A5);
    step();
    rd_en = 1'b1; set_addr(0, 5'd9);
    #1 check_eq("stall_before_reread", port(0), 32'hA5A5A5A5);
    step();
    idle();
    #1 check_eq("reread_r9", port(0), 32'hA5A5A5A5);
    step();

    // Load-use hazard qualification
    idle(); rd_en = 1'b1; set_addr(0, 5'd4); set_addr(1, 5'd3); step();
    idle(); mem_we = 1'b1; mem_load = 1'b1; mem_addr = 5'd3; rd_used = 2'b10;
    #1 check_eq("lu_stall_hit", {31'd0, load_use_stall}, 32'd1);
    rd_used = 2'b00;
    #1 check_eq("lu_unused", {31'd0, load_use_stall}, 32'd0);
    rd_used = 2'b01;
    #1 check_eq("lu_other_port", {31'd0, load_use_stall}, 32'd0);
    step();
    idle(); rd_en = 1'b1; set_addr(1, 5'd0); step();
    idle(); mem_we = 1'b1; mem_load = 1'b1; mem_addr = 5'd0; rd_used = 2'b11;
    #1 check_eq("lu_reg0", {31'd0, load_use_stall}, 32'd0);
    step();

    // Register 0 stays zero after a write
    idle(); wb_we = 1'b1; wb_addr = 5'd0; wb_data = 32'hFFFFFFFF; step();
    idle(); rd_en = 1'b1; step();
    idle();
    #1 check_eq("r0_p0", port(0), 32'd0);
    check_eq("r0_p1", port(1), 32'd0);
    step();

    // Randomized traffic, concentrated on a few indices to provoke hits
    for (int i = 0; i < 400; i++) begin
      rd_en    = ($urandom_range(0, 3) != 0);
      set_addr(0, AW'($urandom_range(0, 7)));
      set_addr(1, AW'($urandom_range(0, 7)));
      rd_used  = NR'($urandom);
      mem_we   = ($urandom_range(0, 2) == 0);
      mem_load = $urandom_range(0, 1) == 1;
      mem_addr = AW'($urandom_range(0, 7));
      mem_data = $urandom;
      wb_we    = ($urandom_range(0, 1) == 1);
      wb_addr  = AW'($urandom_range(0, 7));
      wb_data  = $urandom;
      step();
    end

    // Reset mid-sweep restarts the clear
    idle();
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk) rst = 1'b1;
    repeat (10) @(posedge clk);
    #2 rst = 1'b0;
    #1 check_eq("midsweep_ready", {31'd0, ready}, 32'd0);
    check_eq("midsweep_rd", port(0), 32'd0);
    model_clear();
    @(negedge clk) rst = 1'b1;
    wait_ready("ready_latency_restart");
    read_all();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
